// File: rtl/sonar_pkg.sv
// Shared definitions for the sonar scan sequencer: state encodings, position
// sizing and small elaboration-time helpers.
package sonar_pkg;

    localparam int N_POS_DEF = 8;
    localparam int POS_W     = $clog2(N_POS_DEF);

    typedef logic [3:0] state_t;

    localparam state_t ST_INICIAL        = 4'd0;
    localparam state_t ST_PREPARA        = 4'd1;
    localparam state_t ST_POSICIONA      = 4'd2;
    localparam state_t ST_MEDE           = 4'd3;
    localparam state_t ST_AGUARDA_MEDIDA = 4'd4;
    localparam state_t ST_TRANSMITE      = 4'd5;
    localparam state_t ST_AGUARDA_TX     = 4'd6;
    localparam state_t ST_FIM_POSICAO    = 4'd7;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sonar_scan_timer.sv
// Shared cycle counter for the scan sequencer; tc flags count == terminal.
module sonar_scan_timer
    import sonar_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] terminal,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == terminal);

endmodule

// File: rtl/sonar_scan_controller.sv
// Servo sweep / measure / transmit sequencer for the sonar scanner.
//   state          | meaning
//   INICIAL        | idle, position held
//   PREPARA        | timer cleared, leaving idle or previous position
//   POSICIONA      | servo settling for TIME cycles
//   MEDE           | one-cycle measurement start
//   AGUARDA_MEDIDA | waiting for distance, bounded by TIMEOUT
//   TRANSMITE      | one-cycle serial start
//   AGUARDA_TX     | waiting for frame sent (unbounded)
//   FIM_POSICAO    | end-of-position pulse, sweep advances
module sonar_scan_controller
    import sonar_pkg::*;
#(
    parameter int TIME    = 50_000_000,
    parameter int TIMEOUT = 2_500_000,
    parameter int N_POS   = N_POS_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     ligar,
    input  logic                     medida_pronto,
    input  logic                     envio_pronto,
    output logic [$clog2(N_POS)-1:0] posicao,
    output logic                     medir,
    output logic                     transmitir,
    output logic                     fim_posicao,
    output logic                     erro_timeout,
    output logic [3:0]               db_estado
);

    localparam int PW = $clog2(N_POS);
    localparam int TW = $clog2(max_int(TIME, TIMEOUT) + 1);
    localparam logic [PW-1:0] POS_MAX = PW'(N_POS - 1);
    // Terminal is one less than the duration because count 0 is the first cycle in the state
    localparam logic [TW-1:0] TC_TIME    = TW'(TIME - 1);
    localparam logic [TW-1:0] TC_TIMEOUT = TW'(TIMEOUT - 1);

    state_t          state;
    state_t          state_next;
    logic            dir_up;
    logic            tc;
    logic            timer_clear;
    logic            timer_en;
    logic [TW-1:0]   terminal;

    always_comb begin
        state_next = state;
        case (state)
            ST_INICIAL:        if (ligar) state_next = ST_PREPARA;
            ST_PREPARA:        state_next = ST_POSICIONA;
            ST_POSICIONA:      if (tc) state_next = ST_MEDE;
            ST_MEDE:           state_next = ST_AGUARDA_MEDIDA;
            ST_AGUARDA_MEDIDA: begin
                if (medida_pronto) state_next = ST_TRANSMITE;
                else if (tc)       state_next = ST_FIM_POSICAO;
            end
            ST_TRANSMITE:      state_next = ST_AGUARDA_TX;
            ST_AGUARDA_TX:     if (envio_pronto) state_next = ST_FIM_POSICAO;
            ST_FIM_POSICAO:    state_next = ligar ? ST_PREPARA : ST_INICIAL;
            default:           state_next = ST_INICIAL;
        endcase
    end

    assign timer_clear = (state_next != state);
    assign timer_en    = (state == ST_POSICIONA) || (state == ST_AGUARDA_MEDIDA);
    assign terminal    = (state == ST_AGUARDA_MEDIDA) ? TC_TIMEOUT : TC_TIME;

    sonar_scan_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clock    (clock),
        .reset    (reset),
        .clear    (timer_clear),
        .enable   (timer_en),
        .terminal (terminal),
        .tc       (tc)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ST_INICIAL;
            posicao      <= '0;
            dir_up       <= 1'b1;
            erro_timeout <= 1'b0;
        end else begin
            state <= state_next;

            if (state == ST_INICIAL && ligar) begin
                erro_timeout <= 1'b0;
            end else if (state == ST_AGUARDA_MEDIDA && tc && !medida_pronto) begin
                erro_timeout <= 1'b1;
            end

            // Pendulum: turn around at the ends so endpoints are visited once
            if (state == ST_FIM_POSICAO) begin
                if (dir_up) begin
                    if (posicao == POS_MAX) begin
                        posicao <= posicao - 1'b1;
                        dir_up  <= 1'b0;
                    end else begin
                        posicao <= posicao + 1'b1;
                    end
                end else begin
                    if (posicao == '0) begin
                        posicao <= posicao + 1'b1;
                        dir_up  <= 1'b1;
                    end else begin
                        posicao <= posicao - 1'b1;
                    end
                end
            end
        end
    end

    assign medir       = (state == ST_MEDE);
    assign transmitir  = (state == ST_TRANSMITE);
    assign fim_posicao = (state == ST_FIM_POSICAO);
    assign db_estado   = state;

endmodule

// File: tb/tb_sonar_scan_controller.sv
// Directed bench for sonar_scan_controller with TIME=10, TIMEOUT=20.
module tb_sonar_scan_controller;
    import sonar_pkg::*;

    logic             clock = 1'b0;
    logic             reset;
    logic             ligar;
    logic             medida_pronto;
    logic             envio_pronto;
    logic [POS_W-1:0] posicao;
    logic             medir;
    logic             transmitir;
    logic             fim_posicao;
    logic             erro_timeout;
    logic [3:0]       db_estado;

    int checks   = 0;
    int failures = 0;

    int fim_cnt   = 0;
    int medir_cnt = 0;
    int tx_cnt    = 0;
    int pw_err    = 0;
    logic medir_q = 1'b0;
    logic tx_q    = 1'b0;
    logic fim_q   = 1'b0;

    int exp_seq [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};

    sonar_scan_controller #(
        .TIME    (10),
        .TIMEOUT (20),
        .N_POS   (8)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .ligar         (ligar),
        .medida_pronto (medida_pronto),
        .envio_pronto  (envio_pronto),
        .posicao       (posicao),
        .medir         (medir),
        .transmitir    (transmitir),
        .fim_posicao   (fim_posicao),
        .erro_timeout  (erro_timeout),
        .db_estado     (db_estado)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (fim_posicao === 1'b1) fim_cnt++;
        if (medir === 1'b1) medir_cnt++;
        if (transmitir === 1'b1) tx_cnt++;
        if ((medir && medir_q) || (transmitir && tx_q) || (fim_posicao && fim_q)) pw_err++;
        medir_q = medir;
        tx_q    = transmitir;
        fim_q   = fim_posicao;
    end

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Ticks until medir; exp_n=0 skips the latency check.
    task automatic wait_medir(input int exp_n, input bit stray, input int exp_pos);
        int n;
        n = 0;
        while (medir !== 1'b1 && n < 40) begin
            if (stray && n == 3) begin
                medida_pronto = 1'b1;
                envio_pronto  = 1'b1;
            end
            tick();
            n++;
            medida_pronto = 1'b0;
            envio_pronto  = 1'b0;
        end
        check("medir_seen", medir, 1);
        if (exp_n > 0) check("medir_latency", n, exp_n);
        check("posicao_at_medir", posicao, exp_pos);
    endtask

    // Called at the MEDE cycle; returns at the FIM_POSICAO cycle.
    task automatic finish_position(input int d_med, input int d_env, input bit drop);
        check("mede_db", db_estado, 3);
        repeat (d_med) tick();
        check("aguarda_db", db_estado, 4);
        medida_pronto = 1'b1;
        tick();
        medida_pronto = 1'b0;
        check("transmitir", transmitir, 1);
        check("transmite_db", db_estado, 5);
        tick();
        check("transmitir_end", transmitir, 0);
        if (drop) ligar = 1'b0;
        repeat (d_env - 1) tick();
        check("aguarda_tx_fim_low", fim_posicao, 0);
        envio_pronto = 1'b1;
        tick();
        envio_pronto = 1'b0;
        check("fim_posicao", fim_posicao, 1);
        check("fim_db", db_estado, 7);
    endtask

    initial begin
        int n;
        int tx_base;
        int fim_base;

        reset = 1'b0; ligar = 1'b0; medida_pronto = 1'b0; envio_pronto = 1'b0;
        repeat (2) tick();
        check("rst_posicao", posicao, 0);
        check("rst_medir", medir, 0);
        check("rst_transmitir", transmitir, 0);
        check("rst_fim", fim_posicao, 0);
        check("rst_erro", erro_timeout, 0);
        check("rst_db", db_estado, 0);

        reset = 1'b1;
        repeat (2) tick();
        check("idle_db", db_estado, 0);

        // First position: state walk and start latency
        ligar = 1'b1;
        tick(); n = 1;
        check("db_prepara", db_estado, 1);
        tick(); n = 2;
        check("db_posiciona", db_estado, 2);
        while (medir !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("first_medir_latency", n, 12);
        check("first_posicao", posicao, 0);
        finish_position(5, 7, 1'b0);

        for (int i = 1; i < 16; i++) begin
            wait_medir(12, (i == 4), exp_seq[i]);
            finish_position(5, 7, 1'b0);
        end
        tick();
        check("sweep_fim_count", fim_cnt, 16);
        check("sweep_medir_count", medir_cnt, 16);
        check("sweep_tx_count", tx_cnt, 16);

        // Measurement never arrives
        wait_medir(11, 1'b0, 2);
        tx_base = tx_cnt;
        n = 0;
        while (fim_posicao !== 1'b1 && n < 40) begin
            tick();
            n++;
            if (n == 20) check("erro_before_tc", erro_timeout, 0);
        end
        check("timeout_latency", n, 21);
        check("timeout_erro", erro_timeout, 1);
        check("timeout_db", db_estado, 7);
        tick();
        check("erro_hold", erro_timeout, 1);
        check("timeout_no_tx", tx_cnt - tx_base, 0);

        // Drop ligar mid-position
        wait_medir(11, 1'b0, 3);
        finish_position(5, 7, 1'b1);
        check("erro_hold_fim", erro_timeout, 1);
        tick();
        check("stop_db", db_estado, 0);
        check("stop_posicao", posicao, 4);
        repeat (3) tick();
        check("stop_posicao_hold", posicao, 4);
        check("erro_hold_idle", erro_timeout, 1);

        ligar = 1'b1;
        tick();
        check("resume_db", db_estado, 1);
        check("erro_cleared", erro_timeout, 0);
        wait_medir(11, 1'b0, 4);

        // medida_pronto on the timeout terminal cycle
        finish_position(20, 3, 1'b0);
        check("tie_no_erro", erro_timeout, 0);
        tick();

        // Asynchronous reset in AGUARDA_MEDIDA
        wait_medir(11, 1'b0, 5);
        repeat (2) tick();
        fim_base = fim_cnt;
        #2 reset = 1'b0;
        #1;
        check("arst_posicao", posicao, 0);
        check("arst_medir", medir, 0);
        check("arst_transmitir", transmitir, 0);
        check("arst_fim", fim_posicao, 0);
        check("arst_erro", erro_timeout, 0);
        check("arst_db", db_estado, 0);
        medida_pronto = 1'b1;
        tick();
        medida_pronto = 1'b0;
        tick();
        check("arst_hold_db", db_estado, 0);
        check("arst_hold_tx", transmitir, 0);
        reset = 1'b1;
        wait_medir(12, 1'b0, 0);
        check("arst_no_fim", fim_cnt - fim_base, 0);
        check("pulse_width", pw_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
